mash_sample_sequencer: RTL
==========================

Name: mash_sample_sequencer

Overview:
Feeds the MASH sigma-delta modulator's signed x_in from a small sample FIFO. It holds each sample for exactly OSR modulator clocks and enables the modulator only while a stream is running. It also flags underflow when no sample is ready at a boundary. It sits between the sample source (stimulus logic or a host interface) and the modulator datapath, and replaces the fixed x constant.

Parameters:
DW, 4, sample width (signed two's complement), matches modulator x_in
OSR, 16, modulator clocks per sample (>=2)
DEPTH, 4, FIFO depth in samples (power of 2, >=2)
UF_HOLD, 0, underflow policy: 0 = mute (x_out=0), 1 = repeat last sample

Ports:
clck  in  1  single system/modulator clock, rising edge
rst  in  1  synchronous reset, active-low (sampled on clck rising edge)
enable  in  1  run request
s_data  in  DW  signed input sample
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; push = s_valid && s_ready
uf_clr  in  1  clears sticky underflow
x_out  out  DW  signed sample to modulator x_in
mod_en  out  1  modulator enable
strobe  out  1  one-cycle pulse when x_out takes a new period's value
underflow  out  1  sticky underflow flag
fifo_level  out  clog2(DEPTH+1)  samples stored
busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at an edge): state IDLE; x_out=0, mod_en=0, strobe=0, underflow=0, busy=0; FIFO emptied (fifo_level=0); period counter cnt=0.
- s_ready = rst && (fifo_level != DEPTH), combinational. It is 0 while rst is low, and pushes are ignored during reset.
- FIFO: registered, first-word not bypassed. A push on cycle N is poppable from cycle N+1.
- Simultaneous push and pop: both occur and fifo_level is unchanged. A push is never accepted when full.
- States: IDLE, RUN, DRAIN. All outputs are registered except s_ready.
- IDLE: x_out=0, mod_en=0. When enable=1 and fifo_level>=1, on that edge:
  - pop the head into x_out
  - cnt<=0, mod_en<=1, strobe<=1
  - go to RUN
  If enable=1 with an empty FIFO, stay in IDLE with no underflow.
- RUN: cnt increments each cycle. Boundary = cnt==OSR-1. At the boundary:
  - cnt<=0 and strobe<=1.
  - If fifo_level>=1, pop the head into x_out.
  - Otherwise underflow<=1, and x_out<=0 (UF_HOLD=0) or x_out unchanged (UF_HOLD=1).
  - Stay in RUN; mod_en stays 1.
- RUN with enable=0 at any edge: go to DRAIN. cnt keeps counting and x_out is held.
- DRAIN at the boundary:
  - If enable=1: behave exactly as a RUN boundary, and state<=RUN.
  - Else: x_out<=0, mod_en<=0, strobe<=0, cnt<=0, state<=IDLE. FIFO contents are retained.
- DRAIN before the boundary with enable=1: state<=RUN, no glitch, period length unchanged.
- Result: every sample occupies exactly OSR consecutive cycles of x_out. There are no partial periods except when reset occurs.
- strobe is high only on the first cycle of each sample period. It is never high in IDLE.
- underflow clears on uf_clr=1 unless a new underflow occurs in the same cycle; set wins.
- Width rule: x_out is DW bits signed, passed through with no scaling or saturation.
- Reset mid-operation: all state clears at that edge, and the modulator sees x_out=0 and mod_en=0 from the next cycle. An in-flight period is abandoned.

Test Plan:
1. Reset: rst=0 for 3 cycles with s_valid=1, s_data=0110 -> s_ready=0, fifo_level=0, x_out=0000, mod_en=0, strobe=0 throughout.
2. Steady stream (OSR=16): push 0110, 1010, 0011, then enable=1 -> expected response:
   - x_out=0110 for cycles 1-16, 1010 for 17-32, 0011 for 33-48
   - strobe high at cycles 1, 17, 33 only
   - mod_en=1 from cycle 1
3. Underflow (UF_HOLD=0): push only 0110, enable=1 -> at cycle 17, x_out=0000, underflow=1, strobe=1, mod_en=1. Then pulse uf_clr=1 -> underflow=0. Repeat with UF_HOLD=1 -> x_out stays 0110.
4. Backpressure (DEPTH=4, enable=0): push 5 samples back-to-back -> s_ready drops after the 4th, fifo_level=4, 5th not accepted. Enable, and at the first boundary a simultaneous push+pop keeps fifo_level=3.
5. Drain: in RUN, drop enable at cnt=5 -> x_out held through cnt=15, then x_out=0, mod_en=0, busy=0, and fifo_level unchanged. Re-asserting enable at cnt=10 instead -> continuous stream, next sample at the boundary.
6. Reset mid-RUN at cnt=7 -> next cycle x_out=0000, mod_en=0, fifo_level=0, state IDLE, underflow=0.

Source files
------------

// File: rtl/mash_sample_sequencer.sv
// Sample FIFO and per-sample hold sequencer driving the MASH modulator x_in.
// Each accepted sample drives x_out for exactly OSR clocks while a stream runs.
module mash_sample_sequencer #(
  parameter int DW      = 4,
  parameter int OSR     = 16,
  parameter int DEPTH   = 4,
  parameter int UF_HOLD = 0
) (
  input  logic                       clck,
  input  logic                       rst,
  input  logic                       enable,
  input  logic signed [DW-1:0]       s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       uf_clr,
  output logic signed [DW-1:0]       x_out,
  output logic                       mod_en,
  output logic                       strobe,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST = CW'(OSR-1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic signed [DW-1:0] x_nx;
  logic                 mod_en_nx, strobe_nx, uf_set;
  logic                 push, pop;

  logic signed [DW-1:0] mem [DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;

  assign s_ready = rst && (fifo_level != FULL);
  assign push    = s_valid && s_ready;

  always_ff @(posedge clck)
    if (push) mem[wr_ptr] <= s_data;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clck) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    x_nx      = x_out;
    mod_en_nx = mod_en;
    strobe_nx = 1'b0;
    uf_set    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && fifo_level != '0) begin
          pop       = 1'b1;
          x_nx      = mem[rd_ptr];
          cnt_nx    = '0;
          mod_en_nx = 1'b1;
          strobe_nx = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN, DRAIN: begin
        cnt_nx   = cnt + 1'b1;
        state_nx = enable ? RUN : DRAIN;
        if (cnt == LAST) begin
          cnt_nx = '0;
          // a stream only stops once enable has stayed low into a boundary
          if (state == DRAIN && !enable) begin
            x_nx      = '0;
            mod_en_nx = 1'b0;
            state_nx  = IDLE;
          end else begin
            strobe_nx = 1'b1;
            if (fifo_level != '0) begin
              pop  = 1'b1;
              x_nx = mem[rd_ptr];
            end else begin
              uf_set = 1'b1;
              if (UF_HOLD == 0) x_nx = '0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clck) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      x_out     <= '0;
      mod_en    <= 1'b0;
      strobe    <= 1'b0;
      underflow <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      x_out     <= x_nx;
      mod_en    <= mod_en_nx;
      strobe    <= strobe_nx;
      underflow <= uf_set || (underflow && !uf_clr);
      busy      <= (state_nx != IDLE);
    end
  end
endmodule
